soc_ctrl_regfile: RTL and testbench
===================================

// Module: soc_ctrl_regfile
// PURPOSE
//  Parametrised OBI-subordinate SoC control register file; next generation of the SoC control block.
//  Holds boot address/mode, fetch enable, core status, SRAM delay, NumScratch scratch words,
//  a sticky config lock, a timed software reset-request pulse and a 64-bit free-running cycle counter.
//  Sits on the peripheral OBI crossbar; outputs drive core boot logic, SRAM macros and the reset controller.
// PARAMETERS
//  obi_req_t        logic    OBI request struct (a.addr, a.we, a.be[3:0], a.wdata, a.aid, req)
//  obi_rsp_t        logic    OBI response struct (gnt, rvalid, r.rdata, r.err, r.rid)
//  BootAddrDefault  32'h0    reset value of BOOTADDR / boot_addr_o
//  NumScratch       4        scratch registers, legal range 0..16
//  SramDlyWidth     1        width of SRAM_DLY field, 1..8
//  RstPulseCycles   16       rst_req_o high time in cycles, >= 1
// PORTS
//  clk_i        in   1             clock
//  rst_ni       in   1             asynchronous active-low reset
//  obi_req_i    in   obi_req_t     OBI request
//  obi_rsp_o    out  obi_rsp_t     OBI response
//  boot_addr_o  out  32            BOOTADDR register
//  fetch_en_o   out  1             core fetch enable
//  boot_mode_o  out  1             boot mode select
//  sram_dly_o   out  SramDlyWidth  SRAM timing trim
//  eoc_o        out  1             end-of-computation, = CORESTATUS[31]
//  rst_req_o    out  1             software reset request pulse
// BEHAVIOUR
//  Reset: boot_addr_o=BootAddrDefault; all other outputs, registers, lock, counters, rvalid, err = 0.
//  Handshake: gnt=1 always (comb). Request accepted at cycle n -> rvalid=1 at n+1, rid=aid of n, rdata/err registered.
//  Writes commit at the clock edge ending cycle n; a read at n+1 returns the new value.
//  Byte-enable merge for 32-bit regs: q <= (q & ~bemask) | (wdata & bemask). Narrow fields update only if be[0].
//  Map (addr[7:2] decoded, addr[1:0] ignored):
//   0x00 BOOTADDR rw | 0x04 FETCHEN rw [0] | 0x08 CORESTATUS rw 32 | 0x0C BOOTMODE rw [0]
//   0x10 SRAM_DLY rw [SramDlyWidth-1:0] | 0x14 LOCK: write wdata[0]=1 sets lock, sticky until reset; read [0]
//   0x18 RST_REQ: write wdata[0]=1 starts pulse; read [0]=pulse busy
//   0x1C CYCLE_LO ro: returns cnt[31:0] and snapshots cnt[63:32] into shadow in same cycle
//   0x20 CYCLE_HI ro: returns shadow (atomic 64-bit read = LO then HI)
//   0x40+4*i SCRATCH[i] rw 32, i < NumScratch
//  Lock: while locked, writes to BOOTADDR/BOOTMODE/SRAM_DLY/LOCK are dropped with err=1; others unaffected.
//  Errors: unmapped address (incl. scratch i >= NumScratch) -> err=1, read rdata=32'hBADCAB1E, no state change.
//   Write to CYCLE_LO/HI -> err=1, no effect. Unused read bits return 0.
//  Cycle counter: +1 every cycle from reset, wraps 2^64-1 -> 0; LO read value/snapshot = counter at cycle n.
//  Reset pulse: down-counter loaded with RstPulseCycles on accepted RST_REQ write; rst_req_o=(cnt!=0), registered,
//   rises at n+1, high exactly RstPulseCycles cycles. Write while busy: ignored, err=0, no retrigger.
//  rst_ni assertion mid-pulse or mid-transaction: everything returns to reset values, pending rvalid dropped.
//  req=0: no state change except cycle/pulse counters; rvalid=0 next cycle.
// STRUCTURE
//  Package soc_ctrl_regfile_pkg: register offset localparams, ScratchBase=8'h40, ErrData=32'hBADCAB1E,
//   IntAddrWidth=8, field-width helper function.
//  Sub-module soc_ctrl_rst_pulse (load, busy, pulse_o; parameter Cycles) for the reset-request counter.
//  Scratch array generated with a for-generate; NumScratch=0 must elaborate cleanly.
// TESTING
//  Reset -> read 0x00 = BootAddrDefault, 0x04 = 0, rst_req_o=0, rvalid only cycle after req.
//  Write 0x00 wdata=32'hAABBCCDD be=4'b0101 over 0x11223344 -> read 0x00 = 32'h11BB33DD.
//  Write LOCK=1, then write 0x00=32'h1000 -> err=1, read 0x00 unchanged; write SCRATCH0=5 -> err=0, reads 5.
//  Write RST_REQ=1 (RstPulseCycles=16) -> rst_req_o high 16 cycles; rewrite at cycle 5 -> no extension.
//  Force counter to 64'h0000_0001_FFFF_FFFF, read LO then HI -> 32'hFFFF_FFFF, 32'h1 despite carry.
//  Read 0x40+4*NumScratch and write 0x1C -> err=1, read data 32'hBADCAB1E; back-to-back reqs keep rid order.

Source files
------------

// File: rtl/soc_ctrl_regfile_pkg.sv
// soc_ctrl_regfile_pkg: register map, OBI bus structs and helpers for the SoC control register file
package soc_ctrl_regfile_pkg;
  localparam int unsigned IntAddrWidth = 8;
  localparam logic [7:0] BootAddrOff   = 8'h00;
  localparam logic [7:0] FetchEnOff    = 8'h04;
  localparam logic [7:0] CoreStatusOff = 8'h08;
  localparam logic [7:0] BootModeOff   = 8'h0C;
  localparam logic [7:0] SramDlyOff    = 8'h10;
  localparam logic [7:0] LockOff       = 8'h14;
  localparam logic [7:0] RstReqOff     = 8'h18;
  localparam logic [7:0] CycleLoOff    = 8'h1C;
  localparam logic [7:0] CycleHiOff    = 8'h20;
  localparam logic [7:0] ScratchBase   = 8'h40;
  localparam logic [31:0] ErrData      = 32'hBADCAB1E;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } soc_obi_a_t;
  typedef struct packed {
    soc_obi_a_t a;
    logic       req;
  } soc_obi_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } soc_obi_r_t;
  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    soc_obi_r_t r;
  } soc_obi_rsp_t;
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction
  function automatic logic [31:0] be_merge(input logic [31:0] q, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return (q & ~m) | (d & m);
  endfunction
endpackage

// File: rtl/soc_ctrl_regfile_if.sv
// soc_ctrl_regfile_if: OBI request/response bundle between a crossbar master and the control register file
interface soc_ctrl_regfile_if #(
  parameter type req_t = soc_ctrl_regfile_pkg::soc_obi_req_t,
  parameter type rsp_t = soc_ctrl_regfile_pkg::soc_obi_rsp_t
);
  req_t req;
  rsp_t rsp;
  modport master (output req, input rsp);
  modport slave (input req, output rsp);
endinterface

// File: rtl/soc_ctrl_rst_pulse.sv
// soc_ctrl_rst_pulse: non-retriggerable down-counter producing a fixed-length reset-request pulse
module soc_ctrl_rst_pulse
  import soc_ctrl_regfile_pkg::*;
#(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load,
  output logic busy,
  output logic pulse_o
);
  localparam int unsigned W = cnt_width(Cycles);
  logic [W-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d;
  assign busy = cnt_q != '0;
  assign pulse_o = pulse_q;
  always_comb begin
    cnt_d = busy ? cnt_q - 1'b1 : load ? W'(Cycles) : cnt_q;
    pulse_d = cnt_d != '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
endmodule

// File: rtl/soc_ctrl_regfile.sv
// soc_ctrl_regfile: OBI-subordinate SoC control registers, scratch words, config lock, reset pulse and cycle counter
module soc_ctrl_regfile
  import soc_ctrl_regfile_pkg::*;
#(
  parameter type         obi_req_t       = soc_obi_req_t,
  parameter type         obi_rsp_t       = soc_obi_rsp_t,
  parameter logic [31:0] BootAddrDefault = 32'h0,
  parameter int unsigned NumScratch      = 4,
  parameter int unsigned SramDlyWidth    = 1,
  parameter int unsigned RstPulseCycles  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  soc_ctrl_regfile_if.slave       obi,
  output logic [31:0]             boot_addr_o,
  output logic                    fetch_en_o,
  output logic                    boot_mode_o,
  output logic [SramDlyWidth-1:0] sram_dly_o,
  output logic                    eoc_o,
  output logic                    rst_req_o
);
  obi_req_t req;
  obi_rsp_t rsp;
  logic [IntAddrWidth-1:0] addr;
  logic [3:0] idx, rid_q;
  logic wr, rd, scr_hit, pulse_busy, pulse_load, unused_addr;
  logic [31:0] scratch_rd [16];
  logic [31:0] boot_addr_q, boot_addr_d, core_status_q, core_status_d;
  logic [31:0] shadow_q, shadow_d, rdata_q, rdata_d;
  logic fetch_en_q, fetch_en_d, boot_mode_q, boot_mode_d, lock_q, lock_d, rvalid_q, err_q, err_d;
  logic [SramDlyWidth-1:0] sram_dly_q, sram_dly_d;
  logic [63:0] cnt_q, cnt_d;
  assign req = obi.req;
  assign obi.rsp = rsp;
  assign addr = {req.a.addr[7:2], 2'b00};
  assign idx = req.a.addr[5:2];
  assign unused_addr = ^{req.a.addr[31:8], req.a.addr[1:0]};
  assign wr = req.req & req.a.we;
  assign rd = req.req & ~req.a.we;
  assign scr_hit = (addr[7:6] == ScratchBase[7:6]) && (32'(idx) < NumScratch);
  assign cnt_d = cnt_q + 64'd1;
  assign boot_addr_o = boot_addr_q;
  assign fetch_en_o = fetch_en_q;
  assign boot_mode_o = boot_mode_q;
  assign sram_dly_o = sram_dly_q;
  assign eoc_o = core_status_q[31];
  always_comb begin
    rsp = '0;
    rsp.gnt = 1'b1;
    rsp.rvalid = rvalid_q;
    rsp.r.rdata = rdata_q;
    rsp.r.err = err_q;
    rsp.r.rid = rid_q;
  end
  for (genvar i = 0; i < 16; i++) begin : g_scr
    if (i < NumScratch) begin : g_reg
      logic [31:0] scr_q, scr_d;
      assign scr_d = (wr && scr_hit && idx == 4'(i)) ? be_merge(scr_q, req.a.wdata, req.a.be) : scr_q;
      assign scratch_rd[i] = scr_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) scr_q <= '0;
        else scr_q <= scr_d;
      end
    end else begin : g_nil
      assign scratch_rd[i] = '0;
    end
  end
  always_comb begin
    boot_addr_d = boot_addr_q;
    fetch_en_d = fetch_en_q;
    core_status_d = core_status_q;
    boot_mode_d = boot_mode_q;
    sram_dly_d = sram_dly_q;
    lock_d = lock_q;
    shadow_d = shadow_q;
    rdata_d = '0;
    err_d = 1'b0;
    pulse_load = 1'b0;
    case (addr)
      BootAddrOff: begin
        rdata_d = boot_addr_q;
        err_d = wr & lock_q;
        if (wr & ~lock_q) boot_addr_d = be_merge(boot_addr_q, req.a.wdata, req.a.be);
      end
      FetchEnOff: begin
        rdata_d = 32'(fetch_en_q);
        if (wr & req.a.be[0]) fetch_en_d = req.a.wdata[0];
      end
      CoreStatusOff: begin
        rdata_d = core_status_q;
        if (wr) core_status_d = be_merge(core_status_q, req.a.wdata, req.a.be);
      end
      BootModeOff: begin
        rdata_d = 32'(boot_mode_q);
        err_d = wr & lock_q;
        if (wr & ~lock_q & req.a.be[0]) boot_mode_d = req.a.wdata[0];
      end
      SramDlyOff: begin
        rdata_d = 32'(sram_dly_q);
        err_d = wr & lock_q;
        if (wr & ~lock_q & req.a.be[0]) sram_dly_d = req.a.wdata[SramDlyWidth-1:0];
      end
      LockOff: begin
        rdata_d = 32'(lock_q);
        err_d = wr & lock_q;
        if (wr & req.a.be[0] & req.a.wdata[0]) lock_d = 1'b1;
      end
      RstReqOff: begin
        rdata_d = 32'(pulse_busy);
        pulse_load = wr & req.a.be[0] & req.a.wdata[0];
      end
      CycleLoOff: begin
        rdata_d = cnt_q[31:0];
        err_d = wr;
        if (rd) shadow_d = cnt_q[63:32];
      end
      CycleHiOff: begin
        rdata_d = shadow_q;
        err_d = wr;
      end
      default: begin
        rdata_d = scratch_rd[idx];
        err_d = ~scr_hit;
      end
    endcase
    err_d = err_d & req.req;
    rdata_d = ~req.req ? '0 : err_d ? ErrData : rdata_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr_q <= BootAddrDefault;
      fetch_en_q <= 1'b0;
      core_status_q <= '0;
      boot_mode_q <= 1'b0;
      sram_dly_q <= '0;
      lock_q <= 1'b0;
      shadow_q <= '0;
      cnt_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      rid_q <= '0;
    end else begin
      boot_addr_q <= boot_addr_d;
      fetch_en_q <= fetch_en_d;
      core_status_q <= core_status_d;
      boot_mode_q <= boot_mode_d;
      sram_dly_q <= sram_dly_d;
      lock_q <= lock_d;
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
      rvalid_q <= req.req;
      rdata_q <= rdata_d;
      err_q <= err_d;
      rid_q <= req.a.aid;
    end
  end
  soc_ctrl_rst_pulse #(.Cycles(RstPulseCycles)) u_rst_pulse (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (pulse_load),
    .busy    (pulse_busy),
    .pulse_o (rst_req_o)
  );
endmodule

// File: tb/tb_soc_ctrl_regfile.sv
// tb_soc_ctrl_regfile: directed OBI stimulus checked cycle-by-cycle against a register-map model
module tb_soc_ctrl_regfile;
  import soc_ctrl_regfile_pkg::*;
  localparam logic [31:0] BootDef = 32'h1C00_0080;
  localparam int NS = 4;
  localparam int SW = 3;
  localparam int RPC = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] boot_addr;
  logic fetch_en, boot_mode, eoc, rst_req;
  logic [SW-1:0] sram_dly;
  int n_chk = 0;
  int n_err = 0;
  logic forced = 1'b0;
  logic [3:0] aid_n = '0;
  always #5 clk = ~clk;
  soc_ctrl_regfile_if bus ();
  soc_ctrl_regfile #(
    .BootAddrDefault (BootDef),
    .NumScratch      (NS),
    .SramDlyWidth    (SW),
    .RstPulseCycles  (RPC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .obi         (bus),
    .boot_addr_o (boot_addr),
    .fetch_en_o  (fetch_en),
    .boot_mode_o (boot_mode),
    .sram_dly_o  (sram_dly),
    .eoc_o       (eoc),
    .rst_req_o   (rst_req)
  );
  logic [31:0] m_boot, m_cstat, m_shadow;
  logic [31:0] m_scr [NS];
  logic m_fetch, m_mode, m_lock;
  logic [SW-1:0] m_dly;
  logic [63:0] m_cyc;
  int tcyc, p_lo, p_hi;
  logic e_valid, e_err, e_chk;
  logic [31:0] e_rdata;
  logic [3:0] e_rid;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] q, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (q & ~m) | (d & m);
  endfunction
  // The pulse is described by the cycle window it occupies rather than by a counter.
  function automatic logic busy_at(input int c);
    return c >= p_lo && c <= p_hi;
  endfunction
  task automatic model_txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    logic [7:0] off;
    int i;
    off = {a[7:2], 2'b00};
    i = int'(a[5:2]);
    e_err = 1'b0;
    e_rdata = '0;
    e_chk = !we;
    if (off == 8'h00) begin
      e_rdata = m_boot;
      if (we && m_lock) e_err = 1'b1;
      else if (we) m_boot = merge(m_boot, wd, be);
    end else if (off == 8'h04) begin
      e_rdata = {31'b0, m_fetch};
      if (we && be[0]) m_fetch = wd[0];
    end else if (off == 8'h08) begin
      e_rdata = m_cstat;
      if (we) m_cstat = merge(m_cstat, wd, be);
    end else if (off == 8'h0C) begin
      e_rdata = {31'b0, m_mode};
      if (we && m_lock) e_err = 1'b1;
      else if (we && be[0]) m_mode = wd[0];
    end else if (off == 8'h10) begin
      e_rdata = 32'(m_dly);
      if (we && m_lock) e_err = 1'b1;
      else if (we && be[0]) m_dly = wd[SW-1:0];
    end else if (off == 8'h14) begin
      e_rdata = {31'b0, m_lock};
      if (we && m_lock) e_err = 1'b1;
      else if (we && be[0] && wd[0]) m_lock = 1'b1;
    end else if (off == 8'h18) begin
      e_rdata = {31'b0, busy_at(tcyc)};
      if (we && be[0] && wd[0] && !busy_at(tcyc)) begin
        p_lo = tcyc + 1;
        p_hi = tcyc + RPC;
      end
    end else if (off == 8'h1C) begin
      if (we) e_err = 1'b1;
      else begin
        e_rdata = m_cyc[31:0];
        m_shadow = m_cyc[63:32];
        e_chk = !forced;
      end
    end else if (off == 8'h20) begin
      if (we) e_err = 1'b1;
      else begin
        e_rdata = m_shadow;
        e_chk = !forced;
      end
    end else if (off >= 8'h40 && off < 8'h80 && i < NS) begin
      e_rdata = m_scr[i];
      if (we) m_scr[i] = merge(m_scr[i], wd, be);
    end else e_err = 1'b1;
    if (e_err) e_rdata = ErrData;
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      m_boot = BootDef;
      m_cstat = '0;
      m_shadow = '0;
      for (int i = 0; i < NS; i++) m_scr[i] = '0;
      m_fetch = 1'b0;
      m_mode = 1'b0;
      m_lock = 1'b0;
      m_dly = '0;
      m_cyc = '0;
      tcyc = 0;
      p_lo = 1;
      p_hi = 0;
      e_valid = 1'b0;
      e_err = 1'b0;
      e_chk = 1'b0;
      e_rdata = '0;
      e_rid = '0;
    end else begin
      e_valid = bus.req.req;
      e_rid = bus.req.a.aid;
      if (bus.req.req) model_txn(bus.req.a.addr, bus.req.a.we, bus.req.a.be, bus.req.a.wdata);
      m_cyc = m_cyc + 64'd1;
      tcyc++;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt", 32'(bus.rsp.gnt), 32'd1);
      chk("rvalid", 32'(bus.rsp.rvalid), 32'(e_valid));
      if (e_valid) begin
        chk("rid", 32'(bus.rsp.r.rid), 32'(e_rid));
        chk("err", 32'(bus.rsp.r.err), 32'(e_err));
        if (e_chk) chk("rdata", bus.rsp.r.rdata, e_rdata);
      end
      chk("boot_addr_o", boot_addr, m_boot);
      chk("fetch_en_o", 32'(fetch_en), 32'(m_fetch));
      chk("boot_mode_o", 32'(boot_mode), 32'(m_mode));
      chk("sram_dly_o", 32'(sram_dly), 32'(m_dly));
      chk("eoc_o", 32'(eoc), 32'(m_cstat[31]));
      chk("rst_req_o", 32'(rst_req), 32'(busy_at(tcyc)));
    end
  end
  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    bus.req.req = 1'b1;
    bus.req.a.addr = a;
    bus.req.a.we = we;
    bus.req.a.be = be;
    bus.req.a.wdata = wd;
    bus.req.a.aid = aid_n;
    aid_n = aid_n + 4'd1;
    @(negedge clk);
    bus.req.req = 1'b0;
    rd = bus.rsp.r.rdata;
    er = bus.rsp.r.err;
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int hi;
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rvalid", 32'(bus.rsp.rvalid), 32'd0);
    chk("rst_rst_req", 32'(rst_req), 32'd0);
    chk("rst_boot_addr", boot_addr, BootDef);
    @(negedge clk);
    txn(32'h00, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_bootaddr_default", rd, BootDef);
    txn(32'h04, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_fetchen_reset", rd, 32'h0);
    txn(32'h00, 1'b1, 4'hF, 32'h1122_3344, rd, er);
    txn(32'h00, 1'b1, 4'b0101, 32'hAABB_CCDD, rd, er);
    txn(32'h00, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_be_merge", rd, 32'h11BB_33DD);
    txn(32'h04, 1'b1, 4'h1, 32'h1, rd, er);
    txn(32'h04, 1'b1, 4'h0, 32'h0, rd, er);
    txn(32'h08, 1'b1, 4'hF, 32'h8000_00A5, rd, er);
    txn(32'h08, 1'b1, 4'h2, 32'hFFFF_FFFF, rd, er);
    txn(32'h0C, 1'b1, 4'h1, 32'h1, rd, er);
    txn(32'h10, 1'b1, 4'h0, 32'hFF, rd, er);
    txn(32'h10, 1'b1, 4'h1, 32'hFD, rd, er);
    for (int i = 0; i < 6; i++) txn(32'(4 * i), 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'h02, 1'b0, 4'hF, 32'h0, rd, er);
    for (int i = 0; i < NS; i++) txn(32'h40 + 32'(4 * i), 1'b1, 4'hF, 32'hA0 + 32'(i) * 32'h1111_0000, rd, er);
    txn(32'h44, 1'b1, 4'b0010, 32'h0000_5500, rd, er);
    for (int i = 0; i < NS; i++) txn(32'h40 + 32'(4 * i), 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'h40 + 32'(4 * NS), 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_unmapped_scr_err", 32'(er), 32'd1);
    chk("lit_unmapped_scr_data", rd, 32'hBADC_AB1E);
    txn(32'h24, 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'hFC, 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'h40 + 32'(4 * NS), 1'b1, 4'hF, 32'hDEAD, rd, er);
    txn(32'h1C, 1'b1, 4'hF, 32'h1234, rd, er);
    chk("lit_cyc_lo_write_err", 32'(er), 32'd1);
    txn(32'h20, 1'b1, 4'hF, 32'h1234, rd, er);
    txn(32'h1C, 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'h20, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_cyc_hi_small", rd, 32'h0);
    txn(32'h18, 1'b1, 4'h1, 32'h1, rd, er);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (rst_req) hi++;
      if (k == 4) begin
        txn(32'h18, 1'b1, 4'h1, 32'h1, rd, er);
        chk("lit_retrigger_err", 32'(er), 32'd0);
      end else if (k == 8) txn(32'h18, 1'b0, 4'hF, 32'h0, rd, er);
      else @(negedge clk);
    end
    chk("lit_pulse_len", 32'(hi), 32'd16);
    txn(32'h14, 1'b1, 4'h1, 32'h1, rd, er);
    chk("lit_lock_set_err", 32'(er), 32'd0);
    txn(32'h00, 1'b1, 4'hF, 32'h1000, rd, er);
    chk("lit_locked_write_err", 32'(er), 32'd1);
    txn(32'h00, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_locked_unchanged", rd, 32'h11BB_33DD);
    txn(32'h40, 1'b1, 4'hF, 32'h5, rd, er);
    chk("lit_scratch_unlocked_err", 32'(er), 32'd0);
    txn(32'h40, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_scratch_read", rd, 32'h5);
    txn(32'h0C, 1'b1, 4'h1, 32'h0, rd, er);
    txn(32'h10, 1'b1, 4'h1, 32'h2, rd, er);
    txn(32'h14, 1'b1, 4'h1, 32'h0, rd, er);
    txn(32'h04, 1'b1, 4'h1, 32'h0, rd, er);
    txn(32'h08, 1'b1, 4'h8, 32'h0, rd, er);
    for (int i = 0; i < 9; i++) txn(32'(4 * i), 1'b0, 4'hF, 32'h0, rd, er);
    forced = 1'b1;
    force dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    txn(32'h1C, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_forced_lo", rd, 32'hFFFF_FFFF);
    release dut.cnt_q;
    txn(32'h20, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_forced_hi", rd, 32'h1);
    txn(32'h18, 1'b1, 4'h1, 32'h1, rd, er);
    repeat (3) @(negedge clk);
    bus.req.req = 1'b1;
    bus.req.a.addr = 32'h08;
    bus.req.a.we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_rst_req", 32'(rst_req), 32'd0);
    chk("lit_async_rvalid", 32'(bus.rsp.rvalid), 32'd0);
    chk("lit_async_boot", boot_addr, BootDef);
    repeat (2) @(negedge clk);
    bus.req.req = 1'b0;
    forced = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    txn(32'h14, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_lock_cleared", rd, 32'h0);
    txn(32'h18, 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'h1C, 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'h20, 1'b0, 4'hF, 32'h0, rd, er);
    txn(32'h40, 1'b0, 4'hF, 32'h0, rd, er);
    chk("lit_scratch_after_rst", rd, 32'h0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
